decode_ctrl_stage: RTL
======================

// Module: decode_ctrl_stage
// PURPOSE
//  RV32I(+M) decode stage: decodes a full 32-bit instruction into a registered control/immediate
//  bundle for EX, with valid/ready handshakes on both sides. Detects load-use hazards, holds issue
//  while a multi-cycle M-extension op runs, flags illegal encodings and traps, and honours an EX flush.
//  Sits between the IF/ID register and the ID/EX register; the decoder generation with a wider ALU op.
// PARAMETERS
//  XLEN          32  datapath width; pc and immediate outputs are XLEN bits.
//  EN_MEXT       1   1: OP with funct7=0000001 decodes as an MDU op; 0: it decodes as illegal.
//  ILLEGAL_TRAP  1   1: an illegal instruction enters TRAP; 0: it issues as a NOP with out_illegal=1, no trap.
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous, active-high reset
//  flush          in   1     EX redirect; kills the held bundle and blocks input this cycle
//  mdu_done       in   1     one-cycle pulse from the MDU: the issued M op has completed
//  in_valid       in   1     instruction valid from IF
//  in_ready       out  1     stage accepts in_instr/in_pc this cycle
//  in_instr       in   32    raw instruction
//  in_pc          in   XLEN  instruction address
//  out_valid      out  1     bundle valid to EX
//  out_ready      in   1     EX accepts the bundle
//  out_pc         out  XLEN  registered pc
//  out_imm        out  XLEN  sign-extended immediate (I/S/B/U/J per type; 0 for R-type)
//  out_rd/rs1/rs2 out  5     register indices; forced to 0 when the format has no such field
//  out_funct3     out  3     funct3, used by EX for branch compare and load/store size
//  out_alu_op     out  4     {alt,funct3} for OP/OP_IMM; ADD=0000 for LOAD/STORE/JAL/JALR/AUIPC; PASS_B=1010 for LUI; SUB=1000 for BRANCH
//  out_alu_b_imm  out  1     ALU B operand is out_imm
//  out_reg_write  out  1     write rd; forced 0 when rd==0
//  out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_wb_pc, out_mdu, out_illegal  out 1 each
// BEHAVIOUR
//  Reset: state=RUN; out_valid=0; every out_* data/control output=0; in_ready=0 in the reset cycle.
//  Latency: instruction accepted at edge t appears on out_* after edge t (1 cycle). Throughput 1/cycle.
//  Output register loads when (in_valid && in_ready); clears out_valid on (out_valid && out_ready) with no new load.
//  in_ready = (state==RUN) && !flush && (!out_valid || out_ready) && !lu_hazard.
//  lu_hazard = out_valid && out_mem_read && out_rd!=0 && (rs1-used && rs1==out_rd || rs2-used && rs2==out_rd);
//    this yields exactly one bubble cycle between a load and its dependent instruction.
//  Decode by opcode[6:2] (opcode[1:0] must be 11, else illegal): OP_IMM, OP, LUI, AUIPC, JAL, JALR,
//    BRANCH, LOAD, STORE, MISC_MEM (FENCE: issued as NOP, no writes); anything else is illegal.
//    OP funct7 outside {0000000,0100000, 0000001 if EN_MEXT} is illegal; OP_IMM shifts with bad funct7 are illegal.
//    alt bit = funct7[5] for OP and for OP_IMM SRLI/SRAI only; 0 for all other OP_IMM.
//    JAL/JALR: branch=1, wb_pc=1, reg_write=1. BRANCH: branch=1, wb_pc=0, reg_write=0.
//  An illegal bundle has all write/mem/branch flags 0 and out_illegal=1.
//  FSM (only on an out handshake, i.e. out_valid && out_ready && !flush):
//    RUN -> MDU_WAIT   when the bundle leaving has out_mdu=1.
//    RUN -> TRAP       when the bundle leaving has out_illegal=1 and ILLEGAL_TRAP=1.
//    MDU_WAIT -> RUN   on mdu_done; in_ready=0 while in MDU_WAIT; mdu_done in RUN is ignored.
//    TRAP: in_ready=0, out_valid=0; leaves only on flush or rst.
//  flush (priority over everything but rst): out_valid<=0, state<=RUN, no input accepted. An out
//    handshake in a flush cycle is void on both sides. mdu_done in the same cycle as flush is dropped.
//  Simultaneous out handshake and input load: the new bundle replaces the old with no bubble.
//  rst mid-operation (MDU_WAIT/TRAP/holding a bundle) returns to the reset values next edge.
// STRUCTURE
//  Package ctrl_pkg: opcode[6:2] localparams, 4-bit ALU op encodings, imm-type enum (I,S,B,U,J,NONE),
//    and the FSM state encoding (RUN, MDU_WAIT, TRAP).
//  Sub-module ctrl_decode_comb: purely combinational instr -> control + immediate + illegal
//    (parameters EN_MEXT, XLEN); the top holds the hazard logic, the FSM and the output register.
// TESTING
//  ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, alu_op=0000, alu_b_imm=1, reg_write=1, rd=1.
//  LW x5,0(x2) then ADD x6,x5,x1 back-to-back -> in_ready=0 one cycle, ADD issues 2 cycles after LW.
//  MUL x3,x1,x2 (EN_MEXT=1) -> out_mdu=1, next instr held (in_ready=0) until mdu_done pulse, then accepted.
//  Same MUL with EN_MEXT=0 -> out_illegal=1, state TRAP after handshake; flush -> RUN, in_ready=1 next cycle.
//  out_ready=0 for 3 cycles with BEQ held -> out_* stable, in_ready=0; then ready=1 -> out_imm=B-imm, alu_op=1000.
//  flush asserted with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, instruction not accepted.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode definitions: opcode map, ALU op encodings, immediate formats,
// stage FSM states and the packed control bundle carried from decode to EX.
package ctrl_pkg;

    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_TRAP     = 2'd2
    } state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
        logic [3:0] alu_op;
        logic       alu_b_imm;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       wb_pc;
        logic       mdu;
        logic       illegal;
    } ctrl_bundle_t;

    localparam int CTRL_W = $bits(ctrl_bundle_t);

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e t);
        logic [31:0] imm;
        case (t)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'd0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Combinational RV32I(+M) decoder: raw instruction to control bundle and
// sign-extended immediate. Unused register fields and funct3 are forced to 0.
module ctrl_decode_comb import ctrl_pkg::*; #(
    parameter int XLEN    = 32,
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [31:0]       instr,
    output logic [XLEN-1:0]   imm,
    output logic [CTRL_W-1:0] ctrl
);

    logic [4:0]   opc;
    logic [2:0]   f3;
    logic [6:0]   f7;
    ctrl_bundle_t c;
    imm_type_e    itype;
    logic         use_rd, use_rs1, use_rs2, use_f3, wr, illegal;

    assign opc = instr[6:2];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    always_comb begin
        c       = '0;
        itype   = IMM_NONE;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_f3  = 1'b0;
        wr      = 1'b0;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opc)
                OPC_OP_IMM: begin
                    itype = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; wr = 1'b1;
                    c.alu_b_imm = 1'b1;
                    c.alu_op    = {1'b0, f3};
                    if (f3 == 3'b001 && f7 != F7_BASE) illegal = 1'b1;
                    if (f3 == 3'b101) begin
                        c.alu_op[3] = f7[5];
                        if (f7 != F7_BASE && f7 != F7_ALT) illegal = 1'b1;
                    end
                end
                OPC_OP: begin
                    use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; wr = 1'b1;
                    c.alu_op = {f7[5], f3};
                    if (EN_MEXT && f7 == F7_MEXT) c.mdu = 1'b1;
                    else if (f7 != F7_BASE && f7 != F7_ALT) illegal = 1'b1;
                end
                OPC_LUI: begin
                    itype = IMM_U; use_rd = 1'b1; wr = 1'b1;
                    c.alu_b_imm = 1'b1;
                    c.alu_op    = ALU_PASS_B;
                end
                OPC_AUIPC: begin
                    itype = IMM_U; use_rd = 1'b1; wr = 1'b1;
                    c.alu_b_imm = 1'b1;
                    c.alu_op    = ALU_ADD;
                end
                OPC_JAL: begin
                    itype = IMM_J; use_rd = 1'b1; wr = 1'b1;
                    c.alu_b_imm = 1'b1; c.branch = 1'b1; c.jal = 1'b1; c.wb_pc = 1'b1;
                end
                OPC_JALR: begin
                    itype = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; wr = 1'b1;
                    c.alu_b_imm = 1'b1; c.branch = 1'b1; c.jalr = 1'b1; c.wb_pc = 1'b1;
                end
                OPC_BRANCH: begin
                    itype = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                    c.branch = 1'b1;
                    c.alu_op = ALU_SUB;
                end
                OPC_LOAD: begin
                    itype = IMM_I; use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1; wr = 1'b1;
                    c.alu_b_imm = 1'b1; c.mem_read = 1'b1;
                end
                OPC_STORE: begin
                    itype = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
                    c.alu_b_imm = 1'b1; c.mem_write = 1'b1;
                end
                // FENCE has no architectural effect here: an all-zero NOP bundle.
                OPC_MISC_MEM: ;
                default: illegal = 1'b1;
            endcase
        end
        c.rd        = use_rd  ? instr[11:7]  : 5'd0;
        c.rs1       = use_rs1 ? instr[19:15] : 5'd0;
        c.rs2       = use_rs2 ? instr[24:20] : 5'd0;
        c.funct3    = use_f3  ? f3           : 3'd0;
        c.reg_write = wr && (c.rd != 5'd0);
        if (illegal) begin
            c         = '0;
            c.illegal = 1'b1;
            itype     = IMM_NONE;
        end
    end

    assign ctrl = c;
    assign imm  = XLEN'($signed(imm_gen(instr, itype)));

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode stage: registers the decoded bundle toward EX with load-use stall,
// M-op issue hold, illegal-instruction trap and EX flush.
module decode_ctrl_stage import ctrl_pkg::*; #(
    parameter int XLEN         = 32,
    parameter bit EN_MEXT      = 1'b1,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            mdu_done,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_b_imm,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jal,
    output logic            out_jalr,
    output logic            out_wb_pc,
    output logic            out_mdu,
    output logic            out_illegal,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid && ready at the
    // rising edge; valid never depends on ready, ready may depend on valid.

    logic [XLEN-1:0]   dec_imm;
    logic [CTRL_W-1:0] dec_ctrl_raw;
    ctrl_bundle_t      dec_ctrl;

    state_e            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   pc_q, pc_d, imm_q, imm_d;
    ctrl_bundle_t      ctrl_q, ctrl_d;
    logic              lu_hazard, issue_block, load, out_hs;

    ctrl_decode_comb #(.XLEN(XLEN), .EN_MEXT(EN_MEXT)) u_decode (
        .instr (in_instr),
        .imm   (dec_imm),
        .ctrl  (dec_ctrl_raw)
    );

    assign dec_ctrl = ctrl_bundle_t'(dec_ctrl_raw);

    always_comb begin
        // Unused source fields decode to x0, so a plain compare implies "used".
        lu_hazard = out_valid_q && ctrl_q.mem_read && (ctrl_q.rd != 5'd0) &&
                    ((dec_ctrl.rs1 == ctrl_q.rd) || (dec_ctrl.rs2 == ctrl_q.rd));
        // A bundle that changes FSM state on leaving must not be overtaken.
        issue_block = ctrl_q.mdu || (ctrl_q.illegal && ILLEGAL_TRAP);
        in_ready    = !rst && (state_q == ST_RUN) && !flush && !lu_hazard &&
                      (!out_valid_q || (out_ready && !issue_block));
        load        = in_valid && in_ready;
        out_hs      = out_valid_q && out_ready && !flush;

        state_d     = state_q;
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        ctrl_d      = ctrl_q;

        if (flush) begin
            out_valid_d = 1'b0;
            state_d     = ST_RUN;
        end else begin
            if (load) begin
                out_valid_d = 1'b1;
                pc_d        = in_pc;
                imm_d       = dec_imm;
                ctrl_d      = dec_ctrl;
            end else if (out_hs) begin
                out_valid_d = 1'b0;
            end
            case (state_q)
                ST_RUN: begin
                    if (out_hs && ctrl_q.mdu)
                        state_d = ST_MDU_WAIT;
                    else if (out_hs && ctrl_q.illegal && ILLEGAL_TRAP)
                        state_d = ST_TRAP;
                end
                ST_MDU_WAIT: if (mdu_done) state_d = ST_RUN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = pc_q;
    assign out_imm       = imm_q;
    assign out_rd        = ctrl_q.rd;
    assign out_rs1       = ctrl_q.rs1;
    assign out_rs2       = ctrl_q.rs2;
    assign out_funct3    = ctrl_q.funct3;
    assign out_alu_op    = ctrl_q.alu_op;
    assign out_alu_b_imm = ctrl_q.alu_b_imm;
    assign out_reg_write = ctrl_q.reg_write;
    assign out_mem_read  = ctrl_q.mem_read;
    assign out_mem_write = ctrl_q.mem_write;
    assign out_branch    = ctrl_q.branch;
    assign out_jal       = ctrl_q.jal;
    assign out_jalr      = ctrl_q.jalr;
    assign out_wb_pc     = ctrl_q.wb_pc;
    assign out_mdu       = ctrl_q.mdu;
    assign out_illegal   = ctrl_q.illegal;
    assign dbg_state     = state_q;

endmodule
